// File: rtl/sm83_reg_bus_ctl.sv
// SM83-style shared register-bus controller: round-robin arbitration
// over a precharge / evaluate / sample cycle on dynamic buses A and B.
module sm83_reg_bus_ctl #(
    parameter int NREQ   = 3,
    parameter int T_PCH  = 2,
    parameter int T_EVAL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] gnt,
    output logic            pch_n,
    output logic [NREQ-1:0] drv_a,
    output logic [NREQ-1:0] drv_b,
    output logic            sample,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [PW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        PCH,
        EVAL,
        SAMPLE
    } state_t;

    state_t       r_state;
    idx_t         r_ptr;
    idx_t         r_win;
    logic         r_a;
    logic         r_b;
    logic [3:0]   r_cnt;

    logic [NREQ-1:0] w_valid;
    logic            w_any;
    idx_t            w_base;
    idx_t            w_pick;
    idx_t            w_hi;
    idx_t            w_lo;
    logic            w_hi_found;
    logic            w_lo_found;
    logic [NREQ-1:0] w_onehot;

    function automatic idx_t wrap_inc(idx_t v);
        if (int'(v) == NREQ - 1) return '0;
        else return v + 1'b1;
    endfunction

    assign w_valid = req & (req_a | req_b);
    assign w_any   = |w_valid;

    // Leaving SAMPLE re-arbitrates against the pointer it is about to store.
    assign w_base = (r_state == SAMPLE) ? wrap_inc(r_win) : r_ptr;

    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_hi_found && w_valid[i] && i >= int'(w_base)) begin
                w_hi_found = 1'b1;
                w_hi       = idx_t'(i);
            end
            if (!w_lo_found && w_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo       = idx_t'(i);
            end
        end
        w_pick = w_hi_found ? w_hi : w_lo;
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_onehot[i] = (idx_t'(i) == w_pick);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_cnt   <= '0;
            gnt     <= '0;
            pch_n   <= 1'b0;
            drv_a   <= '0;
            drv_b   <= '0;
            sample  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= PCH;
                        r_cnt   <= '0;
                        r_win   <= w_pick;
                        r_a     <= req_a[w_pick];
                        r_b     <= req_b[w_pick];
                        gnt     <= w_onehot;
                        busy    <= 1'b1;
                        pch_n   <= 1'b0;
                    end
                end
                PCH: begin
                    if (r_cnt == 4'(T_PCH - 1)) begin
                        r_state <= EVAL;
                        r_cnt   <= '0;
                        pch_n   <= 1'b1;
                        drv_a   <= r_a ? gnt : '0;
                        drv_b   <= r_b ? gnt : '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                EVAL: begin
                    if (r_cnt == 4'(T_EVAL - 1)) begin
                        r_state <= SAMPLE;
                        r_cnt   <= '0;
                        drv_a   <= '0;
                        drv_b   <= '0;
                        sample  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    r_ptr  <= wrap_inc(r_win);
                    r_cnt  <= '0;
                    sample <= 1'b0;
                    pch_n  <= 1'b0;
                    if (w_any) begin
                        r_state <= PCH;
                        r_win   <= w_pick;
                        r_a     <= req_a[w_pick];
                        r_b     <= req_b[w_pick];
                        gnt     <= w_onehot;
                    end else begin
                        r_state <= IDLE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_reg_bus_ctl.sv
// Directed and randomized bench for sm83_reg_bus_ctl against a
// bus-cycle timeline model (phase offset within each bus cycle).
module tb_sm83_reg_bus_ctl;

    localparam int N  = 3;
    localparam int TP = 2;
    localparam int TE = 1;
    localparam int L  = TP + TE + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, req_a, req_b;
    logic [N-1:0] gnt, drv_a, drv_b;
    logic         pch_n, sample, busy;

    int checks   = 0;
    int failures = 0;

    bit m_act;
    int m_t, m_win, m_ptr;
    bit m_a, m_b;

    always #5 clk = ~clk;

    sm83_reg_bus_ctl #(.NREQ(N), .T_PCH(TP), .T_EVAL(TE)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .req_a  (req_a),
        .req_b  (req_b),
        .gnt    (gnt),
        .pch_n  (pch_n),
        .drv_a  (drv_a),
        .drv_b  (drv_b),
        .sample (sample),
        .busy   (busy)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_at(logic [N-1:0] v, int j);
        logic [N-1:0] s;
        s = v >> j;
        return s[0];
    endfunction

    function automatic int arb(int p, logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (bit_at(v, (p + k) % N)) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic start_cycle(logic [N-1:0] v);
        m_win = arb(m_ptr, v);
        m_a   = bit_at(req_a, m_win);
        m_b   = bit_at(req_b, m_win);
        m_t   = 0;
        m_act = 1'b1;
    endtask

    task automatic model_reset();
        m_act = 1'b0;
        m_t   = 0;
        m_ptr = 0;
        m_win = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] v;
        v = req & (req_a | req_b);
        if (reset) begin
            model_reset();
        end else if (!m_act) begin
            if (v != 0) start_cycle(v);
        end else if (m_t == L - 1) begin
            m_ptr = (m_win + 1) % N;
            if (v != 0) start_cycle(v);
            else m_act = 1'b0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] one, eg;
        bit ev;
        one = 1;
        eg  = m_act ? (one << m_win) : '0;
        ev  = m_act && m_t >= TP && m_t < TP + TE;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("pch_n", 32'(pch_n), 32'(m_act && m_t >= TP));
        chk("drv_a", 32'(drv_a), 32'((ev && m_a) ? eg : '0));
        chk("drv_b", 32'(drv_b), 32'((ev && m_b) ? eg : '0));
        chk("sample", 32'(sample), 32'(m_act && m_t == L - 1));
        chk("busy", 32'(busy), 32'(m_act));
        chk("contention", 32'(!pch_n && ((drv_a | drv_b) != 0)), 32'(0));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cyc();
        reset = 1'b0;
    endtask

    task automatic drive(logic [N-1:0] r, logic [N-1:0] a, logic [N-1:0] b);
        req   = r;
        req_a = a;
        req_b = b;
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        drive('0, '0, '0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester 0 on bus A; request drops after grant.
        drive(3'b001, 3'b001, 3'b000);
        cyc();
        chk("t1_gnt", 32'(gnt), 32'(3'b001));
        drive('0, '0, '0);
        repeat (5) cyc();
        chk("t1_idle", 32'(busy), 32'(0));

        // Pointer advanced to 1: all requesting favours requester 1.
        drive(3'b111, 3'b111, 3'b000);
        cyc();
        chk("t1_ptr", 32'(gnt), 32'(3'b010));
        drive('0, '0, '0);
        repeat (5) cyc();

        // Request without any bus is ignored.
        drive(3'b010, 3'b000, 3'b000);
        repeat (5) cyc();
        chk("t3_gnt", 32'(gnt), 32'(0));
        chk("t3_pch", 32'(pch_n), 32'(0));

        // Back-to-back round robin from a fresh pointer.
        drive('0, '0, '0);
        do_reset();
        drive(3'b111, 3'b111, 3'b111);
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (c % L == 0) chk("rr_seq", 32'(gnt), 32'(rr_exp[c / L]));
            chk("rr_busy", 32'(busy), 32'(1));
        end
        drive('0, '0, '0);
        repeat (5) cyc();

        // Requester 2 on both buses, request removed during precharge.
        do_reset();
        drive(3'b100, 3'b100, 3'b100);
        cyc();
        drive('0, '0, '0);
        cyc();
        cyc();
        chk("t4_drv_a", 32'(drv_a), 32'(3'b100));
        chk("t4_drv_b", 32'(drv_b), 32'(3'b100));
        cyc();
        chk("t4_sample", 32'(sample), 32'(1));
        repeat (2) cyc();

        // Reset mid-evaluate removes drivers without a clock edge.
        drive(3'b001, 3'b001, 3'b001);
        cyc();
        drive('0, '0, '0);
        cyc();
        cyc();
        chk("t5_in_eval", 32'(drv_a), 32'(3'b001));
        reset = 1'b1;
        #1;
        chk("t5_async_drv_a", 32'(drv_a), 32'(0));
        chk("t5_async_drv_b", 32'(drv_b), 32'(0));
        chk("t5_async_pch", 32'(pch_n), 32'(0));
        model_reset();
        cyc();
        reset = 1'b0;
        drive(3'b110, 3'b110, 3'b000);
        cyc();
        chk("t5_gnt", 32'(gnt), 32'(3'b010));
        drive('0, '0, '0);
        repeat (5) cyc();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(N'($urandom), N'($urandom), N'($urandom));
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm83_reg_bus_ctl.md
SM83_REG_BUS_CTL -- requirements
Module: sm83_reg_bus_ctl

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters sharing the register buses.
REQ-002 SHALL have parameter T_PCH, default 2, precharge cycles per bus cycle (legal range 1..15).
REQ-003 SHALL have parameter T_EVAL, default 1, evaluate cycles per bus cycle (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NREQ  per-requester bus-cycle request.
REQ-007 SHALL have port req_a  input  NREQ  requester needs bus A.
REQ-008 SHALL have port req_b  input  NREQ  requester needs bus B.
REQ-009 SHALL have port gnt  output  NREQ  one-hot grant, held for the whole bus cycle.
REQ-010 SHALL have port pch_n  output  1  active-low precharge enable for both buses A and B.
REQ-011 SHALL have port drv_a  output  NREQ  one-hot enable for the granted requester to discharge bus A.
REQ-012 SHALL have port drv_b  output  NREQ  one-hot enable for the granted requester to discharge bus B.
REQ-013 SHALL have port sample  output  1  one-cycle strobe; bus values are valid for capture.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, PCH, EVAL, SAMPLE; every output SHALL be decoded from registered state only (no combinational path from inputs to outputs).
REQ-016 Requester i SHALL be valid when req[i] && (req_a[i] || req_b[i]); req[i] with both bus bits low SHALL be ignored.
REQ-017 In IDLE, when any requester is valid, the FSM SHALL go to PCH; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a pointer selects the first valid requester at index >= ptr, wrapping modulo NREQ.
REQ-019 The winner, its req_a and its req_b SHALL be latched on the edge that enters PCH, and SHALL stay fixed until SAMPLE is left.
REQ-020 gnt SHALL be one-hot for the latched winner in PCH, EVAL and SAMPLE, and all-zero in IDLE.
REQ-021 PCH SHALL last exactly T_PCH cycles and EVAL exactly T_EVAL cycles, counted by an internal counter cleared on every state entry; SAMPLE SHALL last exactly 1 cycle.
REQ-022 pch_n SHALL be 0 in IDLE and PCH, and 1 in EVAL and SAMPLE; the buses therefore rest precharged.
REQ-023 drv_a[w] SHALL equal the latched req_a, and drv_b[w] the latched req_b, only in EVAL; both SHALL be all-zero in every other state.
REQ-024 drv_a, drv_b and pch_n=0 SHALL never be active in the same cycle (no precharge/discharge contention).
REQ-025 sample SHALL be 1 only in SAMPLE; busy SHALL be 1 in PCH, EVAL and SAMPLE.
REQ-026 On leaving SAMPLE, ptr SHALL become (winner+1) mod NREQ.
REQ-027 From SAMPLE the FSM SHALL go to PCH if any requester is valid (back-to-back, new arbitration with the updated ptr), else to IDLE.
REQ-028 Latency: valid request seen in IDLE at edge N -> PCH from edge N; EVAL from N+T_PCH; SAMPLE at N+T_PCH+T_EVAL.
REQ-029 Deasserting req after the grant SHALL NOT abort the bus cycle; the cycle SHALL complete and pulse sample.
REQ-030 Requests arriving during PCH, EVAL or SAMPLE SHALL be held off by the requester and SHALL NOT alter the current grant.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, pch_n=0, gnt=0, drv_a=0, drv_b=0, sample=0, busy=0, ptr=0, counter=0.
REQ-032 Reset asserted in EVAL SHALL remove drv_a/drv_b immediately, without waiting for a clock edge, and abandon the cycle with no sample pulse.
REQ-033 After reset deasserts, the first arbitration SHALL favour requester 0.

Verification
REQ-034 Reset, then req=3'b001, req_a=3'b001, req_b=0 -> gnt=001 for 4 cycles; pch_n=0 for 2 cycles; drv_a=001 for 1 cycle; sample=1 for 1 cycle; then IDLE, ptr=1.
REQ-035 req=3'b111 held with all bus bits set -> grants 001, 010, 100, 001 back-to-back, each cycle 4 clocks long, with no IDLE between cycles.
REQ-036 req=3'b010 with req_a=req_b=0 -> FSM stays in IDLE, gnt=0, pch_n=0.
REQ-037 Grant to requester 2 with req_a=1, req_b=1, then req dropped during PCH -> drv_a=drv_b=100 in EVAL and sample still pulses.
REQ-038 Reset asserted mid-EVAL -> drv_a/drv_b=0 and pch_n=0 asynchronously; after release, req=3'b110 -> gnt=010.
REQ-039 Every test SHALL check on every cycle that pch_n=0 implies drv_a=drv_b=0.
